// File: rtl/uart_tx_cfg_if.sv
// Byte-stream handshake between an upstream producer and the UART transmitter.
interface uart_tx_cfg_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, none/odd/even parity,
// 1 or 2 stop bits, baud selected at runtime from divisors derived from CLK_HZ.
// The frame configuration is latched at accept so mid-frame input changes are harmless.
module uart_tx_cfg #(
    parameter int CLK_HZ = 50000000,
    parameter int DIV_W  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    uart_tx_cfg_if.slave  up,
    input  logic [2:0]    baud_set,
    input  logic [1:0]    data_bits,
    input  logic [1:0]    parity_mode,
    input  logic          stop2,
    output logic          uart_tx,
    output logic          tx_done,
    output logic          busy
);

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'((CLK_HZ + 32'd4800)  / 32'd9600);
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'((CLK_HZ + 32'd9600)  / 32'd19200);
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'((CLK_HZ + 32'd19200) / 32'd38400);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'((CLK_HZ + 32'd28800) / 32'd57600);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'((CLK_HZ + 32'd57600) / 32'd115200);
    localparam logic [DIV_W-1:0] ONE        = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the selected number of data bits; odd parity is inverted even.
    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] nb,
                                         input logic odd);
        logic [7:0] mask;
        case (nb)
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(d & mask)) ^ odd;
    endfunction

    state_t            state_r, state_n;
    logic [DIV_W-1:0]  cnt_r, cnt_n;
    logic [2:0]        bit_r, bit_n;
    logic              stop_r, stop_n;
    logic [7:0]        data_r;
    logic [1:0]        nbits_r;
    logic [1:0]        pmode_r;
    logic              stop2_r;
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  div_sel_s;
    logic              accept_s, latch_s, done_s, bit_end_s, parity_en_s, line_s;
    logic [2:0]        last_bit_s;
    logic              uart_tx_r, tx_done_r, busy_r;

    assign up.tx_ready  = (state_r == ST_IDLE);
    assign accept_s     = up.tx_valid && (state_r == ST_IDLE);
    assign bit_end_s    = (cnt_r == (div_r - ONE));
    assign last_bit_s   = {1'b0, nbits_r} + 3'd4;
    assign parity_en_s  = (pmode_r == 2'd1) || (pmode_r == 2'd2);
    assign uart_tx      = uart_tx_r;
    assign tx_done      = tx_done_r;
    assign busy         = busy_r;

    // Bit-period selection from the live baud_set input (sampled only at accept).
    always_comb begin
        div_sel_s = DIV_9600;
        case (baud_set)
            3'd1:    div_sel_s = DIV_19200;
            3'd2:    div_sel_s = DIV_38400;
            3'd3:    div_sel_s = DIV_57600;
            3'd4:    div_sel_s = DIV_115200;
            default: div_sel_s = DIV_9600;
        endcase
    end

    // State register with the bit-period counter, data-bit index and stop-bit index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            bit_r   <= 3'd0;
            stop_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            stop_r  <= stop_n;
        end
    end

    // Next-state logic: walk START, DATA, optional PARITY and STOP, one bit per DIV cycles.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        bit_n   = bit_r;
        stop_n  = stop_r;
        latch_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = ST_START;
                    cnt_n   = {DIV_W{1'b0}};
                    latch_s = 1'b1;
                end else begin
                    cnt_n = {DIV_W{1'b0}};
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_n = ST_DATA;
                    cnt_n   = {DIV_W{1'b0}};
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt_r + ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_n = {DIV_W{1'b0}};
                    if (bit_r == last_bit_s) begin
                        state_n = parity_en_s ? ST_PARITY : ST_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + ONE;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_n = ST_STOP;
                    cnt_n   = {DIV_W{1'b0}};
                    stop_n  = 1'b0;
                end else begin
                    cnt_n = cnt_r + ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_n = {DIV_W{1'b0}};
                    if (stop_r == stop2_r) begin
                        state_n = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        stop_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {DIV_W{1'b0}};
            end
        endcase
    end

    // Line level for the coming cycle, registered below so the start bit appears at the accept edge.
    always_comb begin
        line_s = 1'b1;
        case (state_n)
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = data_r[bit_n];
            ST_PARITY: line_s = calc_parity(data_r, nbits_r, (pmode_r == 2'd1));
            default:   line_s = 1'b1;
        endcase
    end

    // Capture payload and frame configuration at accept; held for the whole frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_r  <= 8'h00;
            nbits_r <= 2'd0;
            pmode_r <= 2'd0;
            stop2_r <= 1'b0;
            div_r   <= {DIV_W{1'b0}};
        end else if (latch_s) begin
            data_r  <= up.tx_data;
            nbits_r <= data_bits;
            pmode_r <= parity_mode;
            stop2_r <= stop2;
            div_r   <= div_sel_s;
        end
    end

    // Registered serial line, end-of-frame pulse and busy flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            uart_tx_r <= 1'b1;
            tx_done_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            uart_tx_r <= line_s;
            tx_done_r <= done_s;
            busy_r    <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: every frame is compared cycle by cycle
// against a bit list built from the frame format rules.
module tb_uart_tx_cfg;

    localparam int CLK_HZ = 5000000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] baud_set;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       uart_tx;
    logic       tx_done;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_cfg_if bus ();

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .DIV_W(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .up          (bus.slave),
        .baud_set    (baud_set),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .uart_tx     (uart_tx),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit period rounded to nearest from the nominal baud rate.
    function automatic int ref_div(input logic [2:0] bs);
        real baud;
        case (bs)
            3'd1:    baud = 19200.0;
            3'd2:    baud = 38400.0;
            3'd3:    baud = 57600.0;
            3'd4:    baud = 115200.0;
            default: baud = 9600.0;
        endcase
        return $rtoi(real'(CLK_HZ) / baud + 0.5);
    endfunction

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("idle_line", uart_tx, 1);
            chk("idle_ready", bus.tx_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", tx_done, 0);
            tick();
        end
    endtask

    task automatic do_accept(input logic [7:0] d, input logic [1:0] nb, input logic [1:0] pm,
                             input logic s2, input logic [2:0] bs);
        bus.tx_data  = d;
        data_bits    = nb;
        parity_mode  = pm;
        stop2        = s2;
        baud_set     = bs;
        bus.tx_valid = 1'b1;
        chk("ready_at_accept", bus.tx_ready, 1);
        tick();
    endtask

    // mode 0: plain; 1: scramble inputs mid-frame; 2: keep valid high with next byte; 3: reset in DATA
    task automatic check_frame(input logic [7:0] d, input logic [1:0] nb, input logic [1:0] pm,
                               input logic s2, input logic [2:0] bs, input int mode,
                               input logic [7:0] nd);
        bit q[$];
        int n, ones, div, total;
        n    = int'(nb) + 5;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm == 2'd2) q.push_back(bit'(ones % 2));
        if (pm == 2'd1) q.push_back(bit'(1 - ones % 2));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        div   = ref_div(bs);
        total = q.size() * div;

        if (mode == 2) begin
            bus.tx_data  = nd;
            bus.tx_valid = 1'b1;
        end else begin
            bus.tx_valid = 1'b0;
        end

        for (int c = 0; c < total; c++) begin
            if (mode == 3 && c == 3 * div + div / 2) begin
                rstn = 1'b0;
                #1;
                chk("rst_line", uart_tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", tx_done, 0);
                chk("rst_ready", bus.tx_ready, 1);
                repeat (3) begin
                    tick();
                    chk("rst_hold_done", tx_done, 0);
                    chk("rst_hold_line", uart_tx, 1);
                end
                rstn = 1'b1;
                check_idle(20);
                return;
            end
            if (mode == 1 && c == total / 2) begin
                baud_set     = bs ^ 3'd1;
                parity_mode  = ~pm;
                data_bits    = ~nb;
                stop2        = ~s2;
                bus.tx_data  = 8'($urandom);
                bus.tx_valid = 1'b1;
            end
            if (mode == 1 && c == total - 1) bus.tx_valid = 1'b0;
            chk("line", uart_tx, q[c / div]);
            chk("busy", busy, 1);
            chk("ready", bus.tx_ready, 0);
            chk("done_early", tx_done, 0);
            tick();
        end
        chk("end_done", tx_done, 1);
        chk("end_ready", bus.tx_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_line", uart_tx, 1);
    endtask

    initial begin
        logic [7:0] b0, b1, b2, d;
        logic [1:0] nb, pm;
        logic       s2;
        logic [2:0] bs;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        baud_set     = 3'd0;
        data_bits    = 2'd3;
        parity_mode  = 2'd0;
        stop2        = 1'b0;
        rstn         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_line", uart_tx, 1);
        chk("reset_ready", bus.tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        rstn = 1'b1;
        check_idle(100);

        // 8N1 at 115200, 0xA5
        do_accept(8'hA5, 2'd3, 2'd0, 1'b0, 3'd4);
        check_frame(8'hA5, 2'd3, 2'd0, 1'b0, 3'd4, 0, 8'h00);

        // 5E2 at 9600, 0xFF
        do_accept(8'hFF, 2'd0, 2'd2, 1'b1, 3'd0);
        check_frame(8'hFF, 2'd0, 2'd2, 1'b1, 3'd0, 0, 8'h00);

        // 7O1 0x00 with configuration and data scrambled mid-frame
        do_accept(8'h00, 2'd2, 2'd1, 1'b0, 3'd3);
        check_frame(8'h00, 2'd2, 2'd1, 1'b0, 3'd3, 1, 8'h00);

        // three bytes streamed back-to-back at 115200 8N1
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        do_accept(b0, 2'd3, 2'd0, 1'b0, 3'd4);
        check_frame(b0, 2'd3, 2'd0, 1'b0, 3'd4, 2, b1);
        tick();
        check_frame(b1, 2'd3, 2'd0, 1'b0, 3'd4, 2, b2);
        tick();
        check_frame(b2, 2'd3, 2'd0, 1'b0, 3'd4, 0, 8'h00);
        tick();
        check_idle(50);

        // reset in the middle of DATA, then a clean frame
        d = 8'($urandom);
        do_accept(d, 2'd3, 2'd2, 1'b0, 3'd4);
        check_frame(d, 2'd3, 2'd2, 1'b0, 3'd4, 3, 8'h00);
        d = 8'($urandom);
        do_accept(d, 2'd3, 2'd0, 1'b0, 3'd4);
        check_frame(d, 2'd3, 2'd0, 1'b0, 3'd4, 0, 8'h00);

        // reserved baud and parity codes
        d = 8'($urandom);
        do_accept(d, 2'd0, 2'd3, 1'b0, 3'd6);
        check_frame(d, 2'd0, 2'd3, 1'b0, 3'd6, 0, 8'h00);

        // random frames
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            nb = 2'($urandom_range(0, 3));
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            bs = 3'($urandom_range(1, 4));
            do_accept(d, nb, pm, s2, bs);
            check_frame(d, nb, pm, s2, bs, int'($urandom_range(0, 1)), 8'h00);
        end
        tick();
        check_idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
